// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined two's-complement adder/subtractor with valid/ready handshake
module pipelined_addsub #(
  parameter int WIDTH = 53,
  parameter int CHUNK = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

  logic adv;

  // Rank k is the state entering slice stage k; rank STAGES is the output register.
  logic [STAGES:0]              v_w;
  logic [STAGES:0]              c_w;
  logic [STAGES:0]              z_w;
  logic [STAGES:0][WIDTH-1:0]   s_w;
  logic [STAGES-1:0][WIDTH-1:0] a_w;
  logic [STAGES-1:0][WIDTH-1:0] b_w;

  logic             in_v;
  logic             in_c;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ovf_q;

  assign adv      = !v_w[STAGES] || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_v <= 1'b0;
    end else if (adv) begin
      in_v <= in_valid;
    end
  end

  // Subtraction is folded in here: invert b and turn the borrow-in into a carry-in.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      in_a <= a;
      in_b <= b ^ {WIDTH{sub}};
      in_c <= cin ^ sub;
    end
  end

  assign v_w[0] = in_v;
  assign c_w[0] = in_c;
  assign z_w[0] = 1'b1;
  assign s_w[0] = '0;
  assign a_w[0] = in_a;
  assign b_w[0] = in_b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int SW = ((WIDTH - LO) < CHUNK) ? (WIDTH - LO) : CHUNK;

    logic [SW:0]      part;
    logic             v_r;
    logic             c_r;
    logic             z_r;
    logic [WIDTH-1:0] s_r;

    assign part = {1'b0, a_w[k][LO +: SW]} + {1'b0, b_w[k][LO +: SW]} + {{SW{1'b0}}, c_w[k]};

    // Data only moves with a live beat, so bubbles never disturb the held result.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        z_r <= 1'b0;
        s_r <= '0;
      end else if (adv) begin
        v_r <= v_w[k];
        if (v_w[k]) begin
          c_r           <= part[SW];
          z_r           <= z_w[k] && (part[SW-1:0] == '0);
          s_r           <= s_w[k];
          s_r[LO +: SW] <= part[SW-1:0];
        end
      end
    end

    assign v_w[k+1] = v_r;
    assign c_w[k+1] = c_r;
    assign z_w[k+1] = z_r;
    assign s_w[k+1] = s_r;

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;

      always_ff @(posedge clk) begin
        if (adv && v_w[k]) begin
          a_r <= a_w[k];
          b_r <= b_w[k];
        end
      end

      assign a_w[k+1] = a_r;
      assign b_w[k+1] = b_r;
    end else begin : g_last
      // Carry into the MSB is recovered from the MSB sum bit and its two addend bits.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv && v_w[k]) begin
          ovf_q <= part[SW] ^ (a_w[k][LO+SW-1] ^ b_w[k][LO+SW-1] ^ part[SW-1]);
        end
      end
    end
  end

  assign out_valid = v_w[STAGES];
  assign sum       = s_w[STAGES];
  assign cout      = c_w[STAGES];
  assign zero      = z_w[STAGES];
  assign ovf       = ovf_q;
endmodule
